// File: rtl/irq_arbiter_16.sv
// 16-source interrupt arbiter: latches edge/level requests, masks them, and hands the
// highest-numbered eligible source to the core through a claim/complete handshake.
module irq_arbiter_16 #(
    parameter logic [15:0] EDGE_MASK = 16'hFFFF,
    parameter logic [15:0] EN_RESET  = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] irq_in,
    input  logic        en_we,
    input  logic [15:0] en_wdata,
    output logic [15:0] enable,
    output logic [15:0] pending,
    output logic        irq_req,
    output logic [3:0]  irq_id,
    input  logic        claim,
    input  logic        complete,
    input  logic [3:0]  complete_id,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PEND    = 2'd1,
        SERVICE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] enable_q, enable_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] irq_prev_q;
    logic        irq_req_q, irq_req_d;
    logic [3:0]  irq_id_q, irq_id_d;
    logic        busy_q, busy_d;
    logic [3:0]  in_svc_id_q, in_svc_id_d;

    logic [15:0] svc_mask;
    logic [15:0] eligible;
    logic [3:0]  select;
    logic        any;
    logic        claim_fire;
    logic [15:0] claim_clr;
    logic [15:0] rise;

    // A level source stays asserted through its handler, so hide it until it completes.
    always_comb begin
        svc_mask = '0;
        if (busy_q && !EDGE_MASK[in_svc_id_q]) begin
            svc_mask = 16'(1) << in_svc_id_q;
        end
        eligible = pending_q & enable_q & ~svc_mask;
        select   = '0;
        for (int i = 0; i < 16; i++) begin
            if (eligible[i]) begin
                select = 4'(i);
            end
        end
        any = |eligible;
    end

    always_comb begin
        claim_fire = (state_q == PEND) && claim;
        claim_clr  = claim_fire ? (16'(1) << irq_id_q) : 16'h0000;
        rise       = irq_in & ~irq_prev_q;
        // New edges win over a coincident claim clear so no rising edge is lost.
        pending_d  = (EDGE_MASK & ((pending_q & ~claim_clr) | rise))
                   | (~EDGE_MASK & irq_in);
        enable_d   = en_we ? en_wdata : enable_q;
    end

    always_comb begin
        state_d     = state_q;
        irq_req_d   = irq_req_q;
        irq_id_d    = irq_id_q;
        busy_d      = busy_q;
        in_svc_id_d = in_svc_id_q;
        case (state_q)
            IDLE: begin
                irq_req_d = 1'b0;
                if (any) begin
                    state_d   = PEND;
                    irq_req_d = 1'b1;
                    irq_id_d  = select;
                end
            end
            PEND: begin
                irq_req_d = 1'b1;
                irq_id_d  = select;
                if (claim) begin
                    state_d     = SERVICE;
                    in_svc_id_d = irq_id_q;
                    irq_id_d    = irq_id_q;
                    irq_req_d   = 1'b0;
                    busy_d      = 1'b1;
                end else if (!any) begin
                    state_d   = IDLE;
                    irq_req_d = 1'b0;
                    irq_id_d  = irq_id_q;
                end
            end
            SERVICE: begin
                irq_req_d = 1'b0;
                if (complete && (complete_id == in_svc_id_q)) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                irq_req_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            enable_q    <= EN_RESET;
            pending_q   <= '0;
            irq_prev_q  <= '0;
            irq_req_q   <= 1'b0;
            irq_id_q    <= '0;
            busy_q      <= 1'b0;
            in_svc_id_q <= '0;
        end else begin
            state_q     <= state_d;
            enable_q    <= enable_d;
            pending_q   <= pending_d;
            irq_prev_q  <= irq_in;
            irq_req_q   <= irq_req_d;
            irq_id_q    <= irq_id_d;
            busy_q      <= busy_d;
            in_svc_id_q <= in_svc_id_d;
        end
    end

    assign enable  = enable_q;
    assign pending = pending_q;
    assign irq_req = irq_req_q;
    assign irq_id  = irq_id_q;
    assign busy    = busy_q;

endmodule

// File: doc/irq_arbiter_16.md
Name: irq_arbiter_16

Overview:
Interrupt arbiter/controller that shares the single core trap input between 16 peripheral interrupt sources (timer, VGA vblank, PS/2 keyboard, audio, etc.) in the Doodle Jump RISC-V SoC. It latches requests, applies an enable mask and selects the highest-numbered eligible source (fixed priority, source 15 highest). It presents that source to the core through a claim/complete handshake and allows one interrupt in service at a time (non-nested).

Parameters:
EDGE_MASK, 16'hFFFF, per-source mode: 1 = rising-edge triggered (latched), 0 = level triggered
EN_RESET, 16'h0000, reset value of enable mask

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
irq_in  in  16  raw interrupt lines, already synchronous to clk
en_we  in  1  write strobe for enable mask
en_wdata  in  16  new enable mask value
enable  out  16  current enable mask
pending  out  16  current pending register
irq_req  out  1  interrupt request to core (registered)
irq_id  out  4  selected source ID, valid while irq_req=1 (registered)
claim  in  1  core acknowledges irq_id; single-cycle pulse
complete  in  1  core finished handler; single-cycle pulse
complete_id  in  4  ID being completed
busy  out  1  a source is in service

Behaviour:
- Reset (async, rst_n=0): enable=EN_RESET, pending=0, irq_prev=0, irq_req=0, irq_id=0, busy=0, in_svc_id=0, state=IDLE.
- Pending, edge source i: set when irq_in[i]=1 and irq_prev[i]=0; cleared on claim of i; set wins when set and claim-clear coincide.
- Pending, level source i: pending[i] = irq_in[i] registered each cycle; claim has no effect.
- Eligible vector = pending & enable; for level sources also masked off while that source is in service.
- Select = index of highest set bit of eligible; any = |eligible.
- en_we: enable <= en_wdata next edge; pending bits of disabled sources retained, not eligible.
- FSM:
  - IDLE: irq_req=0. If any -> PEND, irq_req<=1, irq_id<=select.
  - PEND: irq_req=1; irq_id re-registered to select every cycle (higher-priority arrival preempts before claim). If !any (e.g. source disabled) -> IDLE, irq_req<=0. If claim -> SERVICE: in_svc_id<=irq_id, pending[irq_id] cleared (edge), irq_req<=0, busy<=1.
  - SERVICE: irq_req=0; new requests accumulate in pending. complete with complete_id==in_svc_id -> IDLE, busy<=0; if any is still true, the IDLE->PEND pass takes one additional cycle. complete with mismatched ID ignored.
- Ignored inputs: claim in IDLE or SERVICE; complete in IDLE or PEND.
- Claim and complete in the same cycle: act on claim per the current state; complete follows the same ignore rules.
- Latency, edge source: irq_in rises before edge k -> pending set after edge k -> irq_req=1, irq_id valid after edge k+1.
- Re-arm, edge source: irq_in held high does not re-set pending; a new rising edge is required.
- Claim-to-claim minimum: claim, complete, then irq_req reasserts no earlier than 2 cycles after complete.
- Mid-operation reset: everything returns to reset values immediately, regardless of state.

Test Plan:
- Reset, enable=16'h0010, pulse irq_in[4] for 1 cycle -> pending=16'h0010 after 1 edge; irq_req=1, irq_id=4 one edge later; claim -> pending=0, busy=1, irq_req=0.
- enable=16'hFFFF; raise irq_in[3] and irq_in[9] together -> irq_id=9. Claim, complete(9) -> irq_req=1, irq_id=3 two cycles after complete.
- In PEND with irq_id=2, raise irq_in[12] before claim -> irq_id becomes 12 next cycle; claim clears only pending[12]; pending[2] remains.
- SERVICE on ID 5: complete_id=6 -> ignored, busy stays 1; complete_id=5 -> busy=0 next edge.
- enable=16'h0001 with irq_in[0] pending and in PEND; write enable=0 -> irq_req=0 next cycle, pending[0] still 1; re-enable -> irq_req=1, irq_id=0.
- EDGE_MASK=16'hFFFE, level source 0 held high: claim -> no re-request while busy; after complete(0) -> irq_req reasserts with irq_id=0. Assert rst_n=0 mid-SERVICE -> all outputs 0 asynchronously.
